// File: rtl/ysyx_24080006_pkg.sv
// Shared AXI response codes, FSM state encodings and small helpers for the SRAM responder.
package ysyx_24080006_pkg;

  typedef enum logic [1:0] {
    OKAY   = 2'b00,
    EXOKAY = 2'b01,
    SLVERR = 2'b10,
    DECERR = 2'b11
  } resp_e;

  typedef enum logic [1:0] {
    R_IDLE = 2'd0,
    R_WAIT = 2'd1,
    R_DATA = 2'd2
  } RD_STATE_T;

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_DATA = 2'd1,
    W_RESP = 2'd2
  } WR_STATE_T;

  // Address increment per beat; oversize beats still step one full word.
  function automatic logic [2:0] beat_step(input logic [2:0] size);
    if (size > 3'd2) return 3'd4;
    return 3'd1 << size;
  endfunction

  // Response for a single beat: decode miss dominates any protocol error.
  function automatic resp_e beat_resp(input logic hit, input logic size_err, input logic proto_err);
    if (!hit) return DECERR;
    if (size_err || proto_err) return SLVERR;
    return OKAY;
  endfunction

  // Codes are ordered by severity, so the numeric max is the worst response.
  function automatic resp_e resp_max(input resp_e a, input resp_e b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/ysyx_24080006_sram_mem.sv
// Word array with one asynchronous read port and one byte-strobed synchronous write port.
module ysyx_24080006_sram_mem #(
  parameter int DW    = 32,
  parameter int DEPTH = 4096,
  parameter int IW    = $clog2(DEPTH)
) (
  input  logic            clock,
  input  logic            we_i,
  input  logic [IW-1:0]   waddr_i,
  input  logic [DW/8-1:0] wstrb_i,
  input  logic [DW-1:0]   wdata_i,
  input  logic [IW-1:0]   raddr_i,
  output logic [DW-1:0]   rdata_o
);

  logic [DW-1:0] mem_q [DEPTH];

  assign rdata_o = mem_q[raddr_i];

  // Byte-lane write; contents are deliberately never cleared.
  always_ff @(posedge clock) begin
    if (we_i) begin
      for (int i = 0; i < DW/8; i++) begin
        if (wstrb_i[i]) mem_q[waddr_i][8*i +: 8] <= wdata_i[8*i +: 8];
      end
    end
  end

endmodule

// File: rtl/ysyx_24080006_axi_sram.sv
// AXI4 INCR-burst responder in front of a byte-writable word array.
//
// Read FSM
//   state  | meaning
//   R_IDLE | arready high, waiting for an AR handshake
//   R_WAIT | counting down the configured read latency
//   R_DATA | presenting beats until the rlast handshake
// Write FSM
//   state  | meaning
//   W_IDLE | awready high, waiting for an AW handshake
//   W_DATA | wready high, writing awlen+1 beats
//   W_RESP | bvalid high until bready
module ysyx_24080006_axi_sram
  import ysyx_24080006_pkg::*;
#(
  parameter int            AW       = 32,
  parameter int            DW       = 32,
  parameter int            IDW      = 4,
  parameter logic [AW-1:0] BASE     = 32'h8000_0000,
  parameter int            DEPTH    = 4096,
  parameter int            READ_LAT = 2
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            awvalid,
  output logic            awready,
  input  logic [AW-1:0]   awaddr,
  input  logic [IDW-1:0]  awid,
  input  logic [7:0]      awlen,
  input  logic [2:0]      awsize,
  input  logic            wvalid,
  output logic            wready,
  input  logic [DW-1:0]   wdata,
  input  logic [DW/8-1:0] wstrb,
  input  logic            wlast,
  output logic            bvalid,
  input  logic            bready,
  output logic [1:0]      bresp,
  output logic [IDW-1:0]  bid,
  input  logic            arvalid,
  output logic            arready,
  input  logic [AW-1:0]   araddr,
  input  logic [IDW-1:0]  arid,
  input  logic [7:0]      arlen,
  input  logic [2:0]      arsize,
  output logic            rvalid,
  input  logic            rready,
  output logic [DW-1:0]   rdata,
  output logic [1:0]      rresp,
  output logic            rlast,
  output logic [IDW-1:0]  rid
);

  localparam int            IW   = $clog2(DEPTH);
  localparam int            LW   = $clog2(READ_LAT + 2);
  localparam logic [AW-1:0] SPAN = AW'(4 * DEPTH);

  RD_STATE_T rd_state_q, rd_state_d;
  logic [AW-1:0]  rd_addr_q, rd_addr_d;
  logic [IDW-1:0] rd_id_q, rd_id_d;
  logic [7:0]     rd_len_q, rd_len_d, rd_beat_q, rd_beat_d;
  logic [2:0]     rd_size_q, rd_size_d;
  logic [LW-1:0]  rd_cnt_q, rd_cnt_d;
  logic           rd_load, arready_q, rvalid_q, rlast_q;
  logic [DW-1:0]  rdata_q, mem_rdata;
  resp_e          rresp_q;
  logic [AW-1:0]  rd_off, wr_off;
  logic           rd_hit, wr_hit;

  WR_STATE_T wr_state_q, wr_state_d;
  logic [AW-1:0]  wr_addr_q, wr_addr_d;
  logic [IDW-1:0] wr_id_q, wr_id_d;
  logic [7:0]     wr_len_q, wr_len_d, wr_beat_q, wr_beat_d;
  logic [2:0]     wr_size_q, wr_size_d;
  resp_e          wr_acc_q, wr_acc_d;
  logic           awready_q, wready_q, bvalid_q, mem_we;
  resp_e          bresp_q;

  // Offset subtraction wraps, so addresses below BASE decode as misses too.
  assign rd_off = rd_addr_d - BASE;
  assign rd_hit = rd_off < SPAN;
  assign wr_off = wr_addr_q - BASE;
  assign wr_hit = wr_off < SPAN;

  ysyx_24080006_sram_mem #(.DW(DW), .DEPTH(DEPTH), .IW(IW)) u_mem (
    .clock   (clock),
    .we_i    (mem_we),
    .waddr_i (wr_off[IW+1:2]),
    .wstrb_i (wstrb),
    .wdata_i (wdata),
    .raddr_i (rd_off[IW+1:2]),
    .rdata_o (mem_rdata)
  );

  // Read next-state; rd_load marks cycles where the next beat is fetched into the output regs.
  always_comb begin
    rd_state_d = rd_state_q;
    rd_addr_d  = rd_addr_q;
    rd_id_d    = rd_id_q;
    rd_len_d   = rd_len_q;
    rd_size_d  = rd_size_q;
    rd_beat_d  = rd_beat_q;
    rd_cnt_d   = rd_cnt_q;
    rd_load    = 1'b0;
    case (rd_state_q)
      R_IDLE: if (arvalid && arready_q) begin
        rd_addr_d = araddr;
        rd_id_d   = arid;
        rd_len_d  = arlen;
        rd_size_d = arsize;
        rd_beat_d = 8'd0;
        if (READ_LAT == 0) begin
          rd_state_d = R_DATA;
          rd_load    = 1'b1;
        end else begin
          rd_state_d = R_WAIT;
          rd_cnt_d   = LW'(READ_LAT);
        end
      end
      R_WAIT: begin
        rd_cnt_d = rd_cnt_q - LW'(1);
        if (rd_cnt_q == LW'(1)) begin
          rd_state_d = R_DATA;
          rd_load    = 1'b1;
        end
      end
      R_DATA: if (rready) begin
        if (rlast_q) begin
          rd_state_d = R_IDLE;
        end else begin
          rd_addr_d = rd_addr_q + AW'(beat_step(rd_size_q));
          rd_beat_d = rd_beat_q + 8'd1;
          rd_load   = 1'b1;
        end
      end
      default: rd_state_d = R_IDLE;
    endcase
  end

  // Read registers; beat outputs are only reloaded on a fetch so they hold across stalls.
  always_ff @(posedge clock) begin
    if (reset) begin
      rd_state_q <= R_IDLE;
      rd_addr_q  <= '0;
      rd_id_q    <= '0;
      rd_len_q   <= '0;
      rd_size_q  <= '0;
      rd_beat_q  <= '0;
      rd_cnt_q   <= '0;
      arready_q  <= 1'b0;
      rvalid_q   <= 1'b0;
      rdata_q    <= '0;
      rresp_q    <= OKAY;
      rlast_q    <= 1'b0;
    end else begin
      rd_state_q <= rd_state_d;
      rd_addr_q  <= rd_addr_d;
      rd_id_q    <= rd_id_d;
      rd_len_q   <= rd_len_d;
      rd_size_q  <= rd_size_d;
      rd_beat_q  <= rd_beat_d;
      rd_cnt_q   <= rd_cnt_d;
      arready_q  <= (rd_state_d == R_IDLE);
      if (rd_load) begin
        rvalid_q <= 1'b1;
        rdata_q  <= rd_hit ? mem_rdata : '0;
        rresp_q  <= beat_resp(rd_hit, rd_size_d > 3'd2, 1'b0);
        rlast_q  <= (rd_beat_d == rd_len_d);
      end else if (rd_state_d != R_DATA) begin
        rvalid_q <= 1'b0;
        rdata_q  <= '0;
        rresp_q  <= OKAY;
        rlast_q  <= 1'b0;
      end
    end
  end

  // Write next-state; the burst length comes from awlen, wlast is only cross-checked.
  always_comb begin
    wr_state_d = wr_state_q;
    wr_addr_d  = wr_addr_q;
    wr_id_d    = wr_id_q;
    wr_len_d   = wr_len_q;
    wr_size_d  = wr_size_q;
    wr_beat_d  = wr_beat_q;
    wr_acc_d   = wr_acc_q;
    mem_we     = 1'b0;
    case (wr_state_q)
      W_IDLE: if (awvalid && awready_q) begin
        wr_addr_d  = awaddr;
        wr_id_d    = awid;
        wr_len_d   = awlen;
        wr_size_d  = awsize;
        wr_beat_d  = 8'd0;
        wr_acc_d   = OKAY;
        wr_state_d = W_DATA;
      end
      W_DATA: if (wvalid && wready_q) begin
        mem_we   = wr_hit;
        wr_acc_d = resp_max(wr_acc_q, beat_resp(wr_hit, wr_size_q > 3'd2,
                                                wlast && (wr_beat_q != wr_len_q)));
        if (wr_beat_q == wr_len_q) begin
          wr_state_d = W_RESP;
        end else begin
          wr_addr_d = wr_addr_q + AW'(beat_step(wr_size_q));
          wr_beat_d = wr_beat_q + 8'd1;
        end
      end
      W_RESP: if (bready && bvalid_q) wr_state_d = W_IDLE;
      default: wr_state_d = W_IDLE;
    endcase
  end

  // Write registers with handshake outputs derived from the next state.
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_state_q <= W_IDLE;
      wr_addr_q  <= '0;
      wr_id_q    <= '0;
      wr_len_q   <= '0;
      wr_size_q  <= '0;
      wr_beat_q  <= '0;
      wr_acc_q   <= OKAY;
      awready_q  <= 1'b0;
      wready_q   <= 1'b0;
      bvalid_q   <= 1'b0;
      bresp_q    <= OKAY;
    end else begin
      wr_state_q <= wr_state_d;
      wr_addr_q  <= wr_addr_d;
      wr_id_q    <= wr_id_d;
      wr_len_q   <= wr_len_d;
      wr_size_q  <= wr_size_d;
      wr_beat_q  <= wr_beat_d;
      wr_acc_q   <= wr_acc_d;
      awready_q  <= (wr_state_d == W_IDLE);
      wready_q   <= (wr_state_d == W_DATA);
      bvalid_q   <= (wr_state_d == W_RESP);
      bresp_q    <= (wr_state_d == W_RESP) ? wr_acc_d : OKAY;
    end
  end

  assign arready = arready_q;
  assign rvalid  = rvalid_q;
  assign rdata   = rdata_q;
  assign rresp   = rresp_q;
  assign rlast   = rlast_q;
  assign rid     = rd_id_q;
  assign awready = awready_q;
  assign wready  = wready_q;
  assign bvalid  = bvalid_q;
  assign bresp   = bresp_q;
  assign bid     = wr_id_q;

endmodule

// File: doc/ysyx_24080006_axi_sram.md
Name: ysyx_24080006_axi_sram

Overview:
AXI4 responder (slave) backing the core's memory port; it is the far end of the IFU/LSU arbiter's master interface. It serves INCR bursts on independent read and write channels from an internal byte-writable word array. Read latency is configurable so that bus-stall paths can be exercised in simulation.

Parameters:
AW, 32, address width
DW, 32, data width (word = 4 bytes)
IDW, 4, AXI id width
BASE, 32'h8000_0000, first mapped byte address
DEPTH, 4096, array depth in words
READ_LAT, 2, idle cycles between AR handshake and first rvalid

Ports:
clock  in  1  clock
reset  in  1  synchronous, active-high reset
awvalid  in  1  write address valid
awready  out  1  write address ready
awaddr  in  AW  write start byte address
awid  in  IDW  write id
awlen  in  8  write beats minus 1
awsize  in  3  log2 bytes per beat
wvalid  in  1  write data valid
wready  out  1  write data ready
wdata  in  DW  lane-positioned write data
wstrb  in  DW/8  byte enables
wlast  in  1  last write beat
bvalid  out  1  write response valid
bready  in  1  write response ready
bresp  out  2  write response code
bid  out  IDW  equals captured awid
arvalid  in  1  read address valid
arready  out  1  read address ready
araddr  in  AW  read start byte address
arid  in  IDW  read id
arlen  in  8  read beats minus 1
arsize  in  3  log2 bytes per beat
rvalid  out  1  read data valid
rready  in  1  read data ready
rdata  out  DW  full aligned word
rresp  out  2  read response code
rlast  out  1  final read beat
rid  out  IDW  equals captured arid

Behaviour:
- Reset: all outputs 0, both FSMs idle, counters 0. Array contents are not cleared. Reset asserted mid-burst aborts the burst with no further beats or response.
- Read FSM R_IDLE -> R_WAIT -> R_DATA -> R_IDLE.
  - arready=1 only in R_IDLE, registered, so it is first high the cycle after reset deasserts.
  - AR handshake at cycle t captures addr/id/len/size; R_WAIT counts READ_LAT cycles; rvalid rises at t+1+READ_LAT.
- R_DATA:
  - rdata = mem[(addr-BASE)>>2], the full word; the master extracts byte lanes.
  - rdata/rresp/rlast/rid are held stable while rvalid && !rready.
  - On each handshake: addr += 1<<size, beat count increments, next beat in the following cycle (back-to-back when rready is held high).
  - rlast = (beat == len). Handshake on rlast returns the FSM to R_IDLE; arready is high the next cycle.
- Write FSM W_IDLE -> W_DATA -> W_RESP -> W_IDLE.
  - awready=1 only in W_IDLE; wready=1 only in W_DATA. W beats presented before AW simply wait.
  - Each W handshake writes the bytes of wdata where wstrb[i]=1, then addr += 1<<size.
  - Beat count comes from awlen. wlast is checked, not used for termination: wlast asserted at a beat other than beat awlen sets an error flag, and the response becomes SLVERR.
  - After beat awlen, W_RESP holds bvalid=1 until bready; the FSM then returns to W_IDLE.
- Decode: any beat address outside [BASE, BASE+4*DEPTH) gives resp DECERR (2'b11), read data 0, and the write is dropped. For writes the worst code over the burst wins: DECERR > SLVERR > OKAY.
- awsize/arsize > 2 gives SLVERR. The beats are still transferred, with the address stepping by 4.
- The read and write channels run concurrently. When both hit the same word in the same cycle, the read returns the old data; the write is visible to reads from the next cycle.
- Address arithmetic is AW-bit and wraps modulo 2^AW; a wrapped address decodes as out of range.

Decomposition:
- ysyx_24080006_pkg gains:
  - resp enum: OKAY=2'b00, EXOKAY=2'b01, SLVERR=2'b10, DECERR=2'b11
  - RD_STATE_T and WR_STATE_T enums
- Sub-module ysyx_24080006_sram_mem: DEPTH x DW array with one async read port and one byte-strobed synchronous write port. It is instantiated once.

Test Plan:
- Single write then read: AW 0x8000_0010 len0 size2, W 0xDEADBEEF strb 4'hF -> bresp 00; AR same address -> rvalid exactly 3 cycles after the AR cycle, rdata 0xDEADBEEF, rlast 1.
- Byte write: strb 4'b0100, wdata 0x00AB0000 at 0x8000_0012 over 0x11223344 -> read returns 0x11AB3344.
- INCR read burst len3 size2 at 0x8000_0020 with rready toggling 1,0,1,1,0,1 -> 4 beats with the correct words, data held stable during stalls, rlast only on beat 4.
- Out of range: AR 0x7FFF_FFFC -> rresp 11, rdata 0; write to 0x9000_0000 -> bresp 11 and the array is unchanged.
- wlast asserted on beat 2 of a len3 write -> all 4 beats are written, bresp 10.
- Reset asserted during the second beat of a len7 read -> rvalid 0 the next cycle; after release arready is 1 and a new read returns correct data.
